// File: rtl/calc_timer_pkg.sv
// Shared types and limits for the calculator error-recovery countdown timer.
package calc_timer_pkg;

    localparam int TIMER_W       = 4;
    localparam int TIMER_MIN_SEC = 5;
    localparam int TIMER_MAX_SEC = 15;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } timer_state_t;

    function automatic logic cfg_sec_legal(input logic [TIMER_W-1:0] sec);
        int v;
        v = int'(sec);
        return (v >= TIMER_MIN_SEC) && (v <= TIMER_MAX_SEC);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ enabled cycles.
module tick_prescaler #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr || !en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/err_countdown_timer.sv
// Seconds countdown for the "Err XX" window: config register, FSM and time_left counter.
module err_countdown_timer
    import calc_timer_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEFAULT_SEC = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               cancel,
    input  logic               cfg_we,
    input  logic [TIMER_W-1:0] cfg_sec,
    output logic [TIMER_W-1:0] time_left,
    output logic               running,
    output logic               expired,
    output logic               cfg_err,
    output logic [TIMER_W-1:0] cfg_sec_q,
    output logic               dbg_state_o
);

    localparam logic [TIMER_W-1:0] DEFAULT_CFG = TIMER_W'(DEFAULT_SEC);

    timer_state_t       state_q, state_d;
    logic [TIMER_W-1:0] time_left_q, time_left_d;
    logic [TIMER_W-1:0] cfg_sec_d;
    logic               expired_q, expired_d;
    logic               cfg_err_q, cfg_err_d;
    logic               presc_clr;
    logic               tick;

    tick_prescaler #(.CLK_HZ(CLK_HZ)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (state_q == RUN),
        .tick  (tick)
    );

    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        cfg_sec_d   = cfg_sec_q;
        expired_d   = 1'b0;
        cfg_err_d   = 1'b0;
        presc_clr   = 1'b0;

        if (cfg_we) begin
            if (cfg_sec_legal(cfg_sec)) begin
                cfg_sec_d = cfg_sec;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        // Loads use cfg_sec_q, so a same-cycle config write only affects later starts.
        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    state_d     = RUN;
                    time_left_d = cfg_sec_q;
                    presc_clr   = 1'b1;
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d     = IDLE;
                    time_left_d = '0;
                    presc_clr   = 1'b1;
                end else if (start) begin
                    time_left_d = cfg_sec_q;
                    presc_clr   = 1'b1;
                end else if (tick) begin
                    if (time_left_q > TIMER_W'(1)) begin
                        time_left_d = time_left_q - TIMER_W'(1);
                    end else begin
                        time_left_d = '0;
                        expired_d   = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                time_left_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            time_left_q <= '0;
            cfg_sec_q   <= DEFAULT_CFG;
            expired_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_left_q <= time_left_d;
            cfg_sec_q   <= cfg_sec_d;
            expired_q   <= expired_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    assign time_left   = time_left_q;
    assign running     = (state_q == RUN);
    assign expired     = expired_q;
    assign cfg_err     = cfg_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_err_countdown_timer.sv
// Bench for err_countdown_timer: cycle model feeds an expected-output queue, plus directed spot checks.
module tb_err_countdown_timer;

    localparam int W = 11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_sec = 4'd0;
    logic [3:0] time_left;
    logic       running;
    logic       expired;
    logic       cfg_err;
    logic [3:0] cfg_sec_q;
    logic       dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] exp_q[$];

    // reference model state
    int m_tl, m_pre, m_cfg;
    bit m_run;

    err_countdown_timer #(.CLK_HZ(10), .DEFAULT_SEC(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cancel      (cancel),
        .cfg_we      (cfg_we),
        .cfg_sec     (cfg_sec),
        .time_left   (time_left),
        .running     (running),
        .expired     (expired),
        .cfg_err     (cfg_err),
        .cfg_sec_q   (cfg_sec_q),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] pack_out(int tl, bit run, bit ex, bit err, int cfg);
        return {4'(tl), run, ex, err, 4'(cfg)};
    endfunction

    task automatic model_reset();
        m_tl = 0; m_pre = 0; m_cfg = 10; m_run = 0;
    endtask

    // One clock: model the edge, push expectation, clock the DUT, pop and compare.
    task automatic step(input string tag);
        bit ex, err;
        logic [W-1:0] want;
        ex = 0; err = 0;
        if (m_run) begin
            if (cancel) begin
                m_run = 0; m_tl = 0; m_pre = 0;
            end else if (start) begin
                m_tl = m_cfg; m_pre = 0;
            end else if (m_pre == 9) begin
                m_pre = 0;
                m_tl = m_tl - 1;
                if (m_tl == 0) begin
                    m_run = 0; ex = 1;
                end
            end else begin
                m_pre++;
            end
        end else if (start && !cancel) begin
            m_run = 1; m_tl = m_cfg; m_pre = 0;
        end
        if (cfg_we) begin
            if (cfg_sec >= 5) m_cfg = int'(cfg_sec);
            else err = 1;
        end
        exp_q.push_back(pack_out(m_tl, m_run, ex, err, m_cfg));
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        check_eq(tag, {time_left, running, expired, cfg_err, cfg_sec_q}, want);
        start = 0; cancel = 0; cfg_we = 0;
    endtask

    // Runs n idle cycles; reports how many expired pulses were seen and the cycle of the last.
    task automatic run_cycles(input string tag, input int n, output int n_exp, output int at);
        n_exp = 0; at = -1;
        for (int i = 1; i <= n; i++) begin
            step(tag);
            if (expired) begin
                n_exp++; at = i;
            end
        end
    endtask

    task automatic write_cfg(input logic [3:0] v);
        cfg_we = 1; cfg_sec = v;
        step("cfg_write");
    endtask

    int ne, at;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", {time_left, running, expired, cfg_err, cfg_sec_q},
                 pack_out(0, 0, 0, 0, 10));
        rst_n = 1;

        // full default run
        start = 1; step("start10");
        check_eq("start10_tl", time_left, 10);
        check_eq("start10_run", running, 1);
        run_cycles("run10", 9, ne, at);
        check_eq("tl_before_tick", time_left, 10);
        step("tick1");
        check_eq("tl_first_dec", time_left, 9);
        run_cycles("run10", 90, ne, at);
        check_eq("exp10_count", ne, 1);
        check_eq("exp10_cycle", at, 90);
        check_eq("exp10_run", running, 0);
        check_eq("exp10_tl", time_left, 0);
        step("after_exp");
        check_eq("exp_one_cycle", expired, 0);

        // five-second run
        write_cfg(4'd5);
        check_eq("cfg5", cfg_sec_q, 5);
        start = 1; step("start5");
        check_eq("start5_tl", time_left, 5);
        run_cycles("run5", 50, ne, at);
        check_eq("exp5_count", ne, 1);
        check_eq("exp5_cycle", at, 50);

        // illegal config writes
        write_cfg(4'd3);
        check_eq("cfg3_err", cfg_err, 1);
        check_eq("cfg3_keep", cfg_sec_q, 5);
        step("cfg_err_drop");
        check_eq("cfg_err_pulse", cfg_err, 0);
        write_cfg(4'd0);
        check_eq("cfg0_err", cfg_err, 1);
        check_eq("cfg0_keep", cfg_sec_q, 5);
        write_cfg(4'd15);
        check_eq("cfg15", cfg_sec_q, 15);
        write_cfg(4'd10);

        // cancel mid-run
        start = 1; step("start_c");
        run_cycles("pre_cancel", 25, ne, at);
        check_eq("tl_at25", time_left, 8);
        cancel = 1; step("cancel");
        check_eq("cancel_tl", time_left, 0);
        check_eq("cancel_run", running, 0);
        run_cycles("post_cancel", 200, ne, at);
        check_eq("cancel_no_exp", ne, 0);

        // restart mid-run
        start = 1; step("start_r");
        run_cycles("pre_restart", 35, ne, at);
        check_eq("tl_at35", time_left, 7);
        start = 1; step("restart");
        check_eq("restart_tl", time_left, 10);
        run_cycles("post_restart", 100, ne, at);
        check_eq("restart_exp_count", ne, 1);
        check_eq("restart_exp_cycle", at, 100);

        // start and cancel together while idle
        start = 1; cancel = 1; step("start_cancel");
        check_eq("sc_idle", running, 0);

        // start with a same-cycle config write loads the old value
        start = 1; cfg_we = 1; cfg_sec = 4'd6; step("start_cfg");
        check_eq("start_cfg_tl", time_left, 10);
        check_eq("start_cfg_q", cfg_sec_q, 6);
        cancel = 1; step("cancel2");

        // random idle-time config traffic
        for (int i = 0; i < 20; i++) begin
            cfg_we = 1; cfg_sec = 4'($urandom_range(0, 15));
            step("rand_cfg");
        end

        // async reset mid-run
        write_cfg(4'd7);
        start = 1; step("start_rst");
        run_cycles("pre_reset", 32, ne, at);
        check_eq("tl_pre_reset", time_left, 4);
        #2;
        rst_n = 0;
        #1;
        check_eq("async_reset", {time_left, running, expired, cfg_err, cfg_sec_q},
                 pack_out(0, 0, 0, 0, 10));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("held_reset", {time_left, running, expired, cfg_err, cfg_sec_q},
                 pack_out(0, 0, 0, 0, 10));
        rst_n = 1;
        run_cycles("post_reset", 20, ne, at);
        check_eq("post_reset_no_exp", ne, 0);
        check_eq("post_reset_cfg", cfg_sec_q, 10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
